// File: rtl/hazard_scoreboard.sv
// Pipeline hazard control: operand forwarding selects, load-use / RAW stalls,
// branch flush sequencing, memory-wait freeze and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int FWD_EN         = 1,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 16,
    localparam int RW            = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_instr_ready,
    input  logic             i_data_ready,
    input  logic [RW-1:0]    i_id_rs1,
    input  logic [RW-1:0]    i_id_rs2,
    input  logic [RW-1:0]    i_ex_rd,
    input  logic [RW-1:0]    i_ma_rd,
    input  logic [RW-1:0]    i_wb_rd,
    input  logic             i_ex_reg_wr,
    input  logic             i_ma_reg_wr,
    input  logic             i_wb_reg_wr,
    input  logic             i_ex_is_load,
    input  logic             i_ex_branch_taken,
    output logic             o_if_clk_en,
    output logic             o_id_clk_en,
    output logic             o_ex_clk_en,
    output logic             o_ma_clk_en,
    output logic             o_if_flush,
    output logic             o_id_flush,
    output logic [1:0]       o_fwd_rs1,
    output logic [1:0]       o_fwd_rs2,
    output logic [CNT_W-1:0] o_stall_count
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    localparam logic [3:0] LP_RELOAD = 4'(BRANCH_PENALTY - 1);

    state_t           r_state;
    logic [3:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_ex1, w_ma1, w_wb1, w_ex2, w_ma2, w_wb2;
    logic w_raw_stall;
    logic w_flushing;

    assign w_ex1 = i_ex_reg_wr && (i_ex_rd == i_id_rs1) && (i_id_rs1 != '0);
    assign w_ma1 = i_ma_reg_wr && (i_ma_rd == i_id_rs1) && (i_id_rs1 != '0);
    assign w_wb1 = i_wb_reg_wr && (i_wb_rd == i_id_rs1) && (i_id_rs1 != '0);
    assign w_ex2 = i_ex_reg_wr && (i_ex_rd == i_id_rs2) && (i_id_rs2 != '0);
    assign w_ma2 = i_ma_reg_wr && (i_ma_rd == i_id_rs2) && (i_id_rs2 != '0);
    assign w_wb2 = i_wb_reg_wr && (i_wb_rd == i_id_rs2) && (i_id_rs2 != '0);

    // Without forwarding, only the write-first regfile covers a WB producer.
    assign w_raw_stall = (FWD_EN != 0) ? ((w_ex1 || w_ex2) && i_ex_is_load)
                                       : (w_ex1 || w_ex2 || w_ma1 || w_ma2);

    assign w_flushing = i_ex_branch_taken || (r_state == S_FLUSH);

    always_comb begin
        o_fwd_rs1 = 2'b00;
        o_fwd_rs2 = 2'b00;
        if (FWD_EN != 0) begin
            // A load result is not available in EX, so fall through to older stages.
            if (w_ex1 && !i_ex_is_load) o_fwd_rs1 = 2'b01;
            else if (w_ma1)             o_fwd_rs1 = 2'b10;
            else if (w_wb1)             o_fwd_rs1 = 2'b11;
            if (w_ex2 && !i_ex_is_load) o_fwd_rs2 = 2'b01;
            else if (w_ma2)             o_fwd_rs2 = 2'b10;
            else if (w_wb2)             o_fwd_rs2 = 2'b11;
        end
    end

    always_comb begin
        o_if_clk_en = 1'b1;
        o_id_clk_en = 1'b1;
        o_ex_clk_en = 1'b1;
        o_ma_clk_en = 1'b1;
        o_if_flush  = 1'b0;
        o_id_flush  = 1'b0;
        if (!i_data_ready) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_ex_clk_en = 1'b0;
            o_ma_clk_en = 1'b0;
        end else if (w_flushing) begin
            o_if_flush = 1'b1;
            o_id_flush = 1'b1;
        end else if (w_raw_stall || !i_instr_ready) begin
            o_if_clk_en = 1'b0;
            o_id_clk_en = 1'b0;
            o_id_flush  = 1'b1;
        end
    end

    // Flush counter holds the number of FLUSH-state cycles still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 4'd0;
        end else if (i_data_ready) begin
            if (i_ex_branch_taken) begin
                r_flush_cnt <= LP_RELOAD;
                r_state     <= (LP_RELOAD == 4'd0) ? S_RUN : S_FLUSH;
            end else if (r_state == S_FLUSH) begin
                if (r_flush_cnt <= 4'd1) begin
                    r_flush_cnt <= 4'd0;
                    r_state     <= S_RUN;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!o_if_clk_en && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two parameterisations driven in parallel,
// checked every cycle against a flush-budget reference model plus literal checks.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_instr_ready, i_data_ready;
    logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd, i_ma_rd, i_wb_rd;
    logic       i_ex_reg_wr, i_ma_reg_wr, i_wb_reg_wr;
    logic       i_ex_is_load, i_ex_branch_taken;

    logic       a_if_en, a_id_en, a_ex_en, a_ma_en, a_if_fl, a_id_fl;
    logic [1:0] a_f1, a_f2;
    logic [3:0] a_cnt;
    logic       b_if_en, b_id_en, b_ex_en, b_ma_en, b_if_fl, b_id_fl;
    logic [1:0] b_f1, b_f2;
    logic [15:0] b_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int fl_a, fl_b, cnt_a, cnt_b;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(1), .BRANCH_PENALTY(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_instr_ready(i_instr_ready), .i_data_ready(i_data_ready),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_ex_rd(i_ex_rd), .i_ma_rd(i_ma_rd),
        .i_wb_rd(i_wb_rd), .i_ex_reg_wr(i_ex_reg_wr), .i_ma_reg_wr(i_ma_reg_wr),
        .i_wb_reg_wr(i_wb_reg_wr), .i_ex_is_load(i_ex_is_load),
        .i_ex_branch_taken(i_ex_branch_taken),
        .o_if_clk_en(a_if_en), .o_id_clk_en(a_id_en), .o_ex_clk_en(a_ex_en),
        .o_ma_clk_en(a_ma_en), .o_if_flush(a_if_fl), .o_id_flush(a_id_fl),
        .o_fwd_rs1(a_f1), .o_fwd_rs2(a_f2), .o_stall_count(a_cnt));

    hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(0), .BRANCH_PENALTY(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_instr_ready(i_instr_ready), .i_data_ready(i_data_ready),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_ex_rd(i_ex_rd), .i_ma_rd(i_ma_rd),
        .i_wb_rd(i_wb_rd), .i_ex_reg_wr(i_ex_reg_wr), .i_ma_reg_wr(i_ma_reg_wr),
        .i_wb_reg_wr(i_wb_reg_wr), .i_ex_is_load(i_ex_is_load),
        .i_ex_branch_taken(i_ex_branch_taken),
        .o_if_clk_en(b_if_en), .o_id_clk_en(b_id_en), .o_ex_clk_en(b_ex_en),
        .o_ma_clk_en(b_ma_en), .o_if_flush(b_if_fl), .o_id_flush(b_id_fl),
        .o_fwd_rs1(b_f1), .o_fwd_rs2(b_f2), .o_stall_count(b_cnt));

    wire [9:0] a_vec = {a_if_en, a_id_en, a_ex_en, a_ma_en, a_if_fl, a_id_fl, a_f1, a_f2};
    wire [9:0] b_vec = {b_if_en, b_id_en, b_ex_en, b_ma_en, b_if_fl, b_id_fl, b_f1, b_f2};

    function automatic bit hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && (rd == rs) && (rs != 5'd0);
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (hit(i_ex_reg_wr, i_ex_rd, rs) && !i_ex_is_load) return 2'b01;
        if (hit(i_ma_reg_wr, i_ma_rd, rs)) return 2'b10;
        if (hit(i_wb_reg_wr, i_wb_rd, rs)) return 2'b11;
        return 2'b00;
    endfunction

    // Expected {if_en,id_en,ex_en,ma_en,if_fl,id_fl,fwd1,fwd2}; fl = flush cycles still owed.
    function automatic logic [9:0] mdl(input bit fe, input int fl);
        bit e1, e2, m1, m2, raw;
        logic [1:0] f1, f2;
        logic [5:0] ctl;
        e1 = hit(i_ex_reg_wr, i_ex_rd, i_id_rs1);
        e2 = hit(i_ex_reg_wr, i_ex_rd, i_id_rs2);
        m1 = hit(i_ma_reg_wr, i_ma_rd, i_id_rs1);
        m2 = hit(i_ma_reg_wr, i_ma_rd, i_id_rs2);
        raw = fe ? ((e1 || e2) && i_ex_is_load) : (e1 || e2 || m1 || m2);
        f1 = fe ? fsel(i_id_rs1) : 2'b00;
        f2 = fe ? fsel(i_id_rs2) : 2'b00;
        if (!i_data_ready)                     ctl = 6'b0000_00;
        else if (i_ex_branch_taken || fl > 0)  ctl = 6'b1111_11;
        else if (raw || !i_instr_ready)        ctl = 6'b0011_01;
        else                                   ctl = 6'b1111_00;
        return {ctl, f1, f2};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_a <= 0; fl_b <= 0; cnt_a <= 0; cnt_b <= 0;
        end else begin
            if (i_data_ready) begin
                fl_a <= i_ex_branch_taken ? 2 : (fl_a > 0 ? fl_a - 1 : 0);
                fl_b <= i_ex_branch_taken ? 1 : (fl_b > 0 ? fl_b - 1 : 0);
            end
            if (!mdl(1'b1, fl_a)[9] && cnt_a < 15)    cnt_a <= cnt_a + 1;
            if (!mdl(1'b0, fl_b)[9] && cnt_b < 65535) cnt_b <= cnt_b + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("A.outputs", 32'(a_vec), 32'(mdl(1'b1, fl_a)));
        chk("B.outputs", 32'(b_vec), 32'(mdl(1'b0, fl_b)));
        chk("A.stall_count", 32'(a_cnt), 32'(cnt_a));
        chk("B.stall_count", 32'(b_cnt), 32'(cnt_b));
    end

    task automatic idle();
        i_instr_ready = 1'b1; i_data_ready = 1'b1;
        i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_ex_rd = 5'd0; i_ma_rd = 5'd0; i_wb_rd = 5'd0;
        i_ex_reg_wr = 1'b0; i_ma_reg_wr = 1'b0; i_wb_reg_wr = 1'b0;
        i_ex_is_load = 1'b0; i_ex_branch_taken = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        mid();
        chk("reset.A_count", 32'(a_cnt), 32'd0);
        chk("reset.A_enables", 32'({a_if_en, a_id_en, a_ex_en, a_ma_en, a_if_fl, a_id_fl}), 32'h3C);
        next();
        rst_n = 1'b1;
        next();

        // Plain EX forward
        i_id_rs1 = 5'd5; i_ex_rd = 5'd5; i_ex_reg_wr = 1'b1;
        mid();
        chk("fwd_ex.A_fwd1", 32'(a_f1), 32'd1);
        chk("fwd_ex.A_enables", 32'({a_if_en, a_id_en, a_ex_en, a_ma_en}), 32'hF);
        next();

        // Load-use on rs2, also matching MA
        idle();
        i_id_rs2 = 5'd7; i_ex_rd = 5'd7; i_ex_reg_wr = 1'b1; i_ex_is_load = 1'b1;
        i_ma_rd = 5'd7; i_ma_reg_wr = 1'b1;
        mid();
        chk("loaduse.A_fwd2_not_ex", 32'(a_f2 != 2'b01), 32'd1);
        chk("loaduse.A_if_en", 32'(a_if_en), 32'd0);
        chk("loaduse.A_id_flush", 32'(a_id_fl), 32'd1);
        chk("loaduse.A_count_before", 32'(a_cnt), 32'd0);
        next();
        idle();
        mid();
        chk("loaduse.A_count_after", 32'(a_cnt), 32'd1);
        chk("loaduse.A_if_en_after", 32'(a_if_en), 32'd1);
        next();

        // Single branch, penalty 3
        i_ex_branch_taken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk($sformatf("br1.A_flush_c%0d", c), 32'({a_if_fl, a_id_fl}), (c < 3) ? 32'd3 : 32'd0);
            next();
            i_ex_branch_taken = 1'b0;
        end

        // Back-to-back branches extend the flush window
        i_ex_branch_taken = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk($sformatf("br2.A_flush_c%0d", c), 32'({a_if_fl, a_id_fl}), (c < 4) ? 32'd3 : 32'd0);
            next();
            i_ex_branch_taken = (c == 0);
        end

        // Freeze in the middle of a flush
        i_ex_branch_taken = 1'b1;
        next();
        i_ex_branch_taken = 1'b0;
        i_data_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("freeze.A_ctl", 32'({a_if_en, a_id_en, a_ex_en, a_ma_en, a_if_fl, a_id_fl}), 32'h00);
            next();
        end
        i_data_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("resume.A_flush_c%0d", c), 32'({a_if_fl, a_id_fl}), (c < 2) ? 32'd3 : 32'd0);
            next();
        end

        // Stall-only variant
        idle();
        i_id_rs1 = 5'd9; i_ma_rd = 5'd9; i_ma_reg_wr = 1'b1;
        mid();
        chk("nofwd_ma.B_if_en", 32'(b_if_en), 32'd0);
        chk("nofwd_ma.B_fwd1", 32'(b_f1), 32'd0);
        next();
        i_ma_reg_wr = 1'b0; i_wb_rd = 5'd9; i_wb_reg_wr = 1'b1;
        mid();
        chk("nofwd_wb.B_if_en", 32'(b_if_en), 32'd1);
        next();

        // Saturation of the 4-bit counter
        idle();
        i_instr_ready = 1'b0;
        repeat (20) next();
        i_instr_ready = 1'b1;
        mid();
        chk("sat.A_count", 32'(a_cnt), 32'd15);
        next();

        // Asynchronous reset abandons a flush
        i_ex_branch_taken = 1'b1;
        next();
        i_ex_branch_taken = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst.A_count", 32'(a_cnt), 32'd0);
        chk("async_rst.A_flush", 32'({a_if_fl, a_id_fl}), 32'd0);
        chk("async_rst.B_count", 32'(b_cnt), 32'd0);
        next();
        rst_n = 1'b1;
        next();

        // Randomised traffic on a small register window to force frequent matches
        for (int c = 0; c < 2000; c++) begin
            i_id_rs1 = 5'($urandom_range(0, 3));
            i_id_rs2 = 5'($urandom_range(0, 3));
            i_ex_rd  = 5'($urandom_range(0, 3));
            i_ma_rd  = 5'($urandom_range(0, 3));
            i_wb_rd  = 5'($urandom_range(0, 3));
            i_ex_reg_wr = 1'($urandom_range(0, 1));
            i_ma_reg_wr = 1'($urandom_range(0, 1));
            i_wb_reg_wr = 1'($urandom_range(0, 1));
            i_ex_is_load = 1'($urandom_range(0, 2) == 0);
            i_ex_branch_taken = 1'($urandom_range(0, 7) == 0);
            i_instr_ready = 1'($urandom_range(0, 5) != 0);
            i_data_ready = 1'($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            next();
        end
        rst_n = 1'b1;
        idle();
        next();
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, 32, architectural register count; register index width RW = $clog2(NUM_REGS).
REQ-002 Parameter FWD_EN, 1, 1 enables operand forwarding; 0 means stall-only operation.
REQ-003 Parameter BRANCH_PENALTY, 2, number of flush cycles after a taken branch; legal range 1..15.
REQ-004 Parameter CNT_W, 16, width of the stall statistics counter.
REQ-005 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port i_instr_ready  in  1  instruction memory ready.
REQ-008 Port i_data_ready  in  1  data memory ready.
REQ-009 Port i_id_rs1, i_id_rs2  in  RW  ID-stage source registers; index 0 means unused.
REQ-010 Port i_ex_rd, i_ma_rd, i_wb_rd  in  RW  destination register of each stage.
REQ-011 Port i_ex_reg_wr, i_ma_reg_wr, i_wb_reg_wr  in  1  per-stage register write enables.
REQ-012 Port i_ex_is_load  in  1  instruction in EX is a load.
REQ-013 Port i_ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-014 Port o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en  out  1  per-stage advance enables.
REQ-015 Port o_if_flush, o_id_flush  out  1  invalidate the IF/ID and ID/EX pipeline registers.
REQ-016 Port o_fwd_rs1, o_fwd_rs2  out  2  operand source: 00 = regfile, 01 = EX, 10 = MA, 11 = WB.
REQ-017 Port o_stall_count  out  CNT_W  saturating count of cycles in which IF was not advanced.

Function
REQ-018 A stage source matches when: rd == rs, rs != 0, and that stage's reg_wr = 1.
REQ-019 Forwarding, FWD_EN=1:
- Per operand, the first match in the priority order EX > MA > WB is selected.
- An EX match with i_ex_is_load=1 is not forwarded.
- No match gives 00.
REQ-020 Forwarding, FWD_EN=0: o_fwd_rs1 and o_fwd_rs2 are constant 00.
REQ-021 RAW stall, FWD_EN=1: raw_stall = load-use, i.e. either operand matches EX while i_ex_is_load=1.
REQ-022 RAW stall, FWD_EN=0: raw_stall = any EX or MA match; a WB match needs no stall because the regfile is write-first.
REQ-023 FSM states and transitions:
- RUN to FLUSH on i_ex_branch_taken while not frozen; flush_cnt loads BRANCH_PENALTY-1.
- In FLUSH, flush_cnt decrements each unfrozen cycle; FLUSH returns to RUN when flush_cnt==0.
- A new taken branch while in FLUSH reloads flush_cnt.
REQ-024 Combinational outputs use a strict priority order, defined in REQ-025 to REQ-028.
REQ-025 Priority 1 (freeze): when i_data_ready=0, all clk_en = 0, both flushes = 0, and the FSM and flush_cnt hold.
REQ-026 Priority 2 (flush): when i_ex_branch_taken=1 or state==FLUSH, o_if_flush=1 and o_id_flush=1, and all clk_en = 1.
REQ-027 Priority 3 (stall): when raw_stall=1 or i_instr_ready=0, o_if_clk_en=0, o_id_clk_en=0, o_id_flush=1 (bubble into EX), and o_ex_clk_en=1, o_ma_clk_en=1.
REQ-028 Priority 4 (normal): all clk_en = 1 and both flushes = 0.
REQ-029 Forwarding selects are computed every cycle, regardless of priority level.
REQ-030 o_stall_count increments by 1 in every cycle with o_if_clk_en=0, and saturates at 2^CNT_W-1.
REQ-031 A taken branch in the same cycle as a load-use match takes flush priority, and that cycle is not counted as a stall.
REQ-032 The block adds no latency: all enables, flushes and selects are combinational from the current inputs and registered state.

Reset
REQ-033 While rst_n=0, asynchronously: state=RUN, flush_cnt=0, o_stall_count=0.
REQ-034 During reset, outputs follow REQ-025 to REQ-028 with state=RUN.
REQ-035 A reset asserted mid-FLUSH abandons the flush immediately.
REQ-036 After reset release, the first rising edge operates from RUN.

Verification
REQ-037 rs1=5, EX rd=5, ex_reg_wr=1, is_load=0, FWD_EN=1 -> o_fwd_rs1=01, no stall, all clk_en=1.
REQ-038 rs2=7 matches both EX and MA, EX is a load -> o_fwd_rs2 not 01; if_clk_en=0 and id_flush=1 for 1 cycle; o_stall_count goes 0 to 1.
REQ-039 Branch taken in cycle 0 with BRANCH_PENALTY=3:
- if_flush and id_flush = 1 in cycles 0, 1 and 2, and 0 in cycle 3.
- A second taken branch in cycle 1 extends the flush through cycle 3.
REQ-040 i_data_ready=0 for 4 cycles mid-FLUSH -> all clk_en=0 and flush_cnt frozen; the flush resumes and completes the remaining cycles after ready returns.
REQ-041 FWD_EN=0, rs1=9 matches MA -> stall and o_fwd_rs1=00; rs1=9 matching only WB -> no stall.
REQ-042 CNT_W=4, 20 consecutive stall cycles -> o_stall_count=15; rst_n low mid-FLUSH -> count=0 and FSM in RUN with no clock edge.
